// File: rtl/range_sum_unit_if.sv
// Handshake and operand bundle for range_sum_unit.
// The requester drives the job and takes the result; the unit sits on the slave side.
interface range_sum_unit_if #(
  parameter int unsigned SUM_W = 16,
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] first;
  logic [CNT_W-1:0] last;
  logic [CNT_W-1:0] step;
  logic             sat_en;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic             ovf;

  modport master (
    output start, first, last, step, sat_en, out_ready,
    input  busy, out_valid, out_sum, ovf
  );

  modport slave (
    input  start, first, last, step, sat_en, out_ready,
    output busy, out_valid, out_sum, ovf
  );
endinterface

// File: rtl/range_sum_unit.sv
// Sums the arithmetic range first, first+step, ... <= last, one term per clock,
// with optional saturation and a sticky overflow flag.
module range_sum_unit #(
  parameter int unsigned SUM_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  range_sum_unit_if.slave  bus
);

  localparam int unsigned AddW = ((SUM_W > CNT_W) ? SUM_W : CNT_W) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_last;
  logic [CNT_W-1:0] r_step;
  logic             r_sat;
  logic             r_stop;
  logic [SUM_W-1:0] r_sum;
  logic             r_ovf;
  logic             r_busy;
  logic             r_valid;

  logic [CNT_W-1:0] w_step;
  logic [CNT_W:0]   w_n_next;
  logic [AddW-1:0]  w_add;
  logic             w_carry;

  assign w_step   = (r_step == '0) ? CNT_W'(1) : r_step;
  assign w_n_next = {1'b0, r_n} + {1'b0, w_step};
  assign w_add    = AddW'(r_sum) + AddW'(r_n);
  // Any bit at or above SUM_W means the true sum no longer fits the accumulator.
  assign w_carry  = |w_add[AddW-1:SUM_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_n     <= '0;
      r_last  <= '0;
      r_step  <= '0;
      r_sat   <= 1'b0;
      r_stop  <= 1'b0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_n     <= bus.first;
            r_last  <= bus.last;
            r_step  <= bus.step;
            r_sat   <= bus.sat_en;
            r_stop  <= 1'b0;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= StRun;
          end
        end
        StRun: begin
          if (r_stop || (r_n > r_last)) begin
            r_valid <= 1'b1;
            r_state <= StDone;
          end else begin
            if (w_carry) begin
              r_ovf <= 1'b1;
            end
            r_sum <= (w_carry && r_sat) ? '1 : w_add[SUM_W-1:0];
            // A counter carry means this was the last term; n is left unwrapped.
            if (w_n_next[CNT_W]) begin
              r_stop <= 1'b1;
            end else begin
              r_n <= w_n_next[CNT_W-1:0];
            end
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.out_valid = r_valid;
  assign bus.out_sum   = r_sum;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_range_sum_unit.sv
// Directed bench for range_sum_unit: default build on bus a, SUM_W=8 build on bus b.
module tb_range_sum_unit;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;
  int   lat;

  range_sum_unit_if #(.SUM_W(16), .CNT_W(8)) ba ();
  range_sum_unit_if #(.SUM_W(8),  .CNT_W(8)) bb ();

  range_sum_unit #(.SUM_W(16), .CNT_W(8)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ba)
  );

  range_sum_unit #(.SUM_W(8), .CNT_W(8)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [31:0] sum_of(input bit sel);
    return sel ? 32'(bb.out_sum) : 32'(ba.out_sum);
  endfunction

  function automatic logic valid_of(input bit sel);
    return sel ? bb.out_valid : ba.out_valid;
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? bb.busy : ba.busy;
  endfunction

  function automatic logic ovf_of(input bit sel);
    return sel ? bb.ovf : ba.ovf;
  endfunction

  // Returns at #1 after the accepting edge E0 with start already dropped.
  task automatic start_job(input bit sel, input int f, input int l, input int s, input bit sat);
    @(negedge clk);
    if (sel) begin
      bb.first = 8'(f); bb.last = 8'(l); bb.step = 8'(s); bb.sat_en = sat; bb.start = 1'b1;
    end else begin
      ba.first = 8'(f); ba.last = 8'(l); ba.step = 8'(s); ba.sat_en = sat; ba.start = 1'b1;
    end
    @(posedge clk);
    #1;
    ba.start = 1'b0;
    bb.start = 1'b0;
  endtask

  task automatic wait_valid(input bit sel, output int edges);
    edges = 0;
    while (valid_of(sel) !== 1'b1 && edges < 300) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("valid_seen", 32'(valid_of(sel)), 32'd1);
  endtask

  task automatic do_job(input string tag, input bit sel, input int f, input int l, input int s,
                        input bit sat, input int exp_sum, input bit exp_ovf, input int exp_lat);
    int e;
    start_job(sel, f, l, s, sat);
    wait_valid(sel, e);
    check({tag, "_lat"}, 32'(e), 32'(exp_lat));
    check({tag, "_sum"}, sum_of(sel), 32'(exp_sum));
    check({tag, "_ovf"}, 32'(ovf_of(sel)), 32'(exp_ovf));
    check({tag, "_busy_done"}, 32'(busy_of(sel)), 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_busy_after"}, 32'(busy_of(sel)), 32'd0);
    check({tag, "_valid_after"}, 32'(valid_of(sel)), 32'd0);
    check({tag, "_sum_hold"}, sum_of(sel), 32'(exp_sum));
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b1;
    ba.start = 1'b0; ba.first = '0; ba.last = '0; ba.step = '0; ba.sat_en = 1'b0;
    ba.out_ready = 1'b1;
    bb.start = 1'b0; bb.first = '0; bb.last = '0; bb.step = '0; bb.sat_en = 1'b0;
    bb.out_ready = 1'b1;
    #23;
    check("rst_busy",  32'(ba.busy), 32'd0);
    check("rst_valid", 32'(ba.out_valid), 32'd0);
    check("rst_sum",   32'(ba.out_sum), 32'd0);
    check("rst_ovf",   32'(ba.ovf), 32'd0);
    check("rst_sum_b", 32'(bb.out_sum), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_job("basic", 1'b0, 1, 10, 1, 1'b0, 55, 1'b0, 11);
    do_job("sat8", 1'b1, 1, 30, 1, 1'b1, 255, 1'b1, 31);
    do_job("wrap8", 1'b1, 1, 30, 1, 1'b0, 209, 1'b1, 31);
    do_job("cntend", 1'b0, 250, 255, 1, 1'b0, 1515, 1'b0, 7);
    do_job("step0", 1'b0, 1, 9, 0, 1'b0, 45, 1'b0, 10);
    do_job("empty", 1'b0, 20, 10, 1, 1'b0, 0, 1'b0, 1);
    do_job("step3", 1'b0, 2, 11, 3, 1'b0, 26, 1'b0, 5);

    // Start pulse and operand changes mid-run must not disturb or queue.
    start_job(1'b0, 1, 4, 1, 1'b0);
    @(negedge clk);
    ba.first = 8'd100; ba.last = 8'd200; ba.step = 8'd3; ba.sat_en = 1'b1; ba.start = 1'b1;
    @(posedge clk);
    #1;
    ba.start = 1'b0;
    wait_valid(1'b0, lat);
    check("busy_start_lat", 32'(lat + 1), 32'd5);
    check("busy_start_sum", 32'(ba.out_sum), 32'd10);
    repeat (3) @(posedge clk);
    #1;
    check("busy_no_queue", 32'(ba.busy), 32'd0);

    // Back-pressure: result must hold while out_ready is low.
    ba.out_ready = 1'b0;
    start_job(1'b0, 1, 5, 1, 1'b0);
    wait_valid(1'b0, lat);
    check("hold_lat", 32'(lat), 32'd6);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(ba.out_valid), 32'd1);
      check("hold_sum", 32'(ba.out_sum), 32'd15);
    end
    @(negedge clk);
    ba.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_release", 32'(ba.busy), 32'd0);

    // Asynchronous reset mid-run aborts the job.
    start_job(1'b0, 1, 10, 1, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy",  32'(ba.busy), 32'd0);
    check("abort_valid", 32'(ba.out_valid), 32'd0);
    check("abort_sum",   32'(ba.out_sum), 32'd0);
    check("abort_ovf",   32'(ba.ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_job("post_rst", 1'b0, 1, 10, 1, 1'b0, 55, 1'b0, 11);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
